multi_rport_axi_memory: RTL and testbench
=========================================

// Module: multi_rport_axi_memory
// PURPOSE
//  Banked on-chip memory for the accelerator: Num_Subbanks subbanks of Subbank_size words.
//  Filled through one AXI-style burst write port using a flat address.
//  Drained through one shared read address that returns the same offset from every subbank
//  in parallel, one read lane per subbank, each lane with its own valid/ready.
// PARAMETERS
//  Num_Subbanks  32  number of subbanks = number of read lanes
//  Subbank_size  32  words per subbank (power of 2)
//  word_size     32  stored word width; must equal DATA_WIDTH
//  R_ADDR_WIDTH   5  read offset width = log2(Subbank_size)
//  W_ADDR_WIDTH  10  flat write address width = log2(Num_Subbanks*Subbank_size)
//  DATA_WIDTH    32  data bus width
// PORTS
//  ACLK     in   1   clock; all logic on rising edge
//  ARESETn  in   1   reset; synchronous, active-high (asserted when 1)
//  W_EN     in   1   write-port enable
//  R_EN     in   1   read-port enable
//  AWVALID/AWREADY  in/out  1   write-address handshake
//  AWADDR   in   W_ADDR_WIDTH   burst start address; subbank=AWADDR/Subbank_size, offset=AWADDR%Subbank_size
//  AWBURST  in   1   1=INCR, 0=FIXED
//  AWLEN    in   8   beats-1
//  WVALID/WREADY    in/out  1   write-data handshake
//  WDATA    in   DATA_WIDTH     write beat data
//  WLAST    in   1   last beat
//  BVALID/BREADY    out/in  1   write-response handshake
//  BRESP    out  2   00=OKAY, 10=SLVERR
//  ARVALID/ARREADY  in/out  1   read-address handshake
//  ARADDR   in   R_ADDR_WIDTH   offset read from all subbanks
//  RVALID   out  [0:Num_Subbanks-1]   per-lane valid; lane i = subbank i
//  RREADY   in   [0:Num_Subbanks-1]   per-lane ready
//  RDATA    out  [0:Num_Subbanks-1][DATA_WIDTH-1:0]  per-lane data
//  RRESP    out  [0:Num_Subbanks-1][1:0]   per-lane response; always 00
// BEHAVIOUR
//  Reset:
//   - All outputs 0.
//   - Memory contents cleared to 0.
//   - Write FSM returns to IDLE; any burst in progress is abandoned and gets no B response.
//   - All pending read lanes are dropped.
//  Write FSM, IDLE -> DATA -> RESP -> IDLE:
//   - IDLE: AWREADY=W_EN. On AWVALID&AWREADY, latch addr, AWBURST and beat count=AWLEN+1.
//     Move to DATA on the next cycle.
//   - DATA: WREADY=1. Each WVALID&WREADY beat writes WDATA to the current address in the same edge.
//     INCR: address +1 per beat, wrapping modulo 2^W_ADDR_WIDTH. FIXED: address held.
//     Leave DATA on the beat with WLAST=1 or on the final counted beat, whichever comes first.
//   - RESP: BVALID=1 and BRESP held until BREADY, then IDLE.
//     BRESP=10 if any beat addressed >= Num_Subbanks*Subbank_size; such beats are not written.
//     Otherwise BRESP=00.
//  Read port, independent of the write FSM:
//   - ARREADY = R_EN & ~|RVALID.
//   - On ARVALID&ARREADY, the next cycle sets every lane i: RVALID[i]=1, RDATA[i]=mem[i][ARADDR], RRESP[i]=00.
//   - Lane i holds RVALID/RDATA until RREADY[i]; RVALID[i] clears the cycle after the handshake.
//     Lanes drain independently.
//   - With all RREADY=1, a read costs 2 cycles (AR accept, data beat).
//  Simultaneous events:
//   - A read and a write to the same word in the same edge: the read returns the old data.
//   - W_EN or R_EN deasserting mid-transaction only blocks new address handshakes.
//     A transaction already in progress completes.
// TESTING
//  - Load pattern: INCR bursts at AWADDR=32*s, AWLEN=31, WDATA=AWADDR+i+1, for s=0..31.
//    Required: 32 WREADY beats per burst, BVALID once per burst with BRESP=00.
//  - After the load, ARADDR=k with all RREADY=1. Required: next cycle RVALID=all ones,
//    RDATA[i]=32*i+k+1 for every lane. Check k=0, 5, 31.
//  - FIXED burst at AWADDR=37, AWLEN=3, data A,B,C,D. Required: ARADDR=5 gives RDATA[1]=D;
//    words 38..40 unchanged.
//  - RREADY[3]=0, others 1, read ARADDR=2. Required: only RVALID[3] stays high, ARREADY=0;
//    after RREADY[3]=1, ARREADY returns to 1.
//  - W_EN=0 with AWVALID=1. Required: AWREADY stays 0 and memory is unchanged.
//  - Assert ARESETn in the middle of the beats of a burst. Required: no BVALID;
//    AWREADY=1 after release when W_EN=1.

Source files
------------

// File: rtl/multi_rport_axi_memory.sv
// Banked on-chip memory: one AXI-style burst write port with a flat address, and one shared
// read address that returns the same offset from every subbank on independent lanes.
module multi_rport_axi_memory #(
  parameter int unsigned Num_Subbanks = 32,
  parameter int unsigned Subbank_size = 32,
  parameter int unsigned word_size    = 32,
  parameter int unsigned R_ADDR_WIDTH = 5,
  parameter int unsigned W_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH   = 32
) (
  input  logic                                    ACLK,
  input  logic                                    ARESETn,
  input  logic                                    W_EN,
  input  logic                                    R_EN,
  input  logic                                    AWVALID,
  output logic                                    AWREADY,
  input  logic [W_ADDR_WIDTH-1:0]                 AWADDR,
  input  logic                                    AWBURST,
  input  logic [7:0]                              AWLEN,
  input  logic                                    WVALID,
  output logic                                    WREADY,
  input  logic [DATA_WIDTH-1:0]                   WDATA,
  input  logic                                    WLAST,
  output logic                                    BVALID,
  input  logic                                    BREADY,
  output logic [1:0]                              BRESP,
  input  logic                                    ARVALID,
  output logic                                    ARREADY,
  input  logic [R_ADDR_WIDTH-1:0]                 ARADDR,
  output logic [0:Num_Subbanks-1]                 RVALID,
  input  logic [0:Num_Subbanks-1]                 RREADY,
  output logic [0:Num_Subbanks-1][DATA_WIDTH-1:0] RDATA,
  output logic [0:Num_Subbanks-1][1:0]            RRESP
);

  localparam int unsigned Depth = Num_Subbanks * Subbank_size;
  localparam int unsigned SbW   = W_ADDR_WIDTH - R_ADDR_WIDTH;
  localparam int unsigned CntW  = 9;

  typedef enum logic [1:0] {IDLE, DATA, RESP} wstate_e;

  wstate_e                 state_q, state_d;
  logic [W_ADDR_WIDTH-1:0] addr_q;
  logic                    incr_q;
  logic [CntW-1:0]         cnt_q;
  logic                    err_q;
  logic [1:0]              bresp_q;
  logic                    aw_ready, w_ready;
  logic                    aw_fire, w_fire, w_oob, ar_fire;
  logic [SbW-1:0]          w_sb;
  logic [R_ADDR_WIDTH-1:0] w_off;

  // Handshake readies are forced low while reset is held so every output reads 0.
  assign AWREADY = aw_ready & ~ARESETn;
  assign WREADY  = w_ready & ~ARESETn;
  assign ARREADY = R_EN & ~|RVALID & ~ARESETn;
  assign BVALID  = (state_q == RESP);
  assign BRESP   = bresp_q;

  assign aw_fire = AWVALID & AWREADY;
  assign w_fire  = WVALID & WREADY;
  assign ar_fire = ARVALID & ARREADY;
  assign w_oob   = (32'(addr_q) >= 32'(Depth));
  assign w_sb    = addr_q[W_ADDR_WIDTH-1:R_ADDR_WIDTH];
  assign w_off   = addr_q[R_ADDR_WIDTH-1:0];

  always_ff @(posedge ACLK) begin
    if (ARESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        aw_ready = W_EN;
        if (AWVALID && W_EN) state_d = DATA;
      end
      DATA: begin
        w_ready = 1'b1;
        if (WVALID && (WLAST || cnt_q == CntW'(1))) state_d = RESP;
      end
      RESP: begin
        if (BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst address/count tracking and sticky out-of-range error.
  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      addr_q  <= '0;
      incr_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      bresp_q <= 2'b00;
    end else begin
      if (aw_fire) begin
        addr_q <= AWADDR;
        incr_q <= AWBURST;
        cnt_q  <= CntW'(AWLEN) + CntW'(1);
        err_q  <= 1'b0;
      end else if (w_fire) begin
        if (incr_q) addr_q <= addr_q + W_ADDR_WIDTH'(1);
        cnt_q <= cnt_q - CntW'(1);
        err_q <= err_q | w_oob;
      end
      if (state_q == DATA && state_d == RESP)
        bresp_q <= (err_q | w_oob) ? 2'b10 : 2'b00;
    end
  end

  for (genvar s = 0; s < Num_Subbanks; s++) begin : g_sb
    logic [word_size-1:0]  mem_q [Subbank_size];
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Nonblocking update means a same-edge read sees the pre-write word.
    always_ff @(posedge ACLK) begin
      if (ARESETn) begin
        mem_q    <= '{default: '0};
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        if (w_fire && !w_oob && w_sb == SbW'(s)) mem_q[w_off] <= WDATA;
        if (ar_fire) begin
          rvalid_q <= 1'b1;
          rdata_q  <= mem_q[ARADDR];
        end else if (rvalid_q && RREADY[s]) begin
          rvalid_q <= 1'b0;
        end
      end
    end

    assign RVALID[s] = rvalid_q;
    assign RDATA[s]  = rdata_q;
    assign RRESP[s]  = 2'b00;
  end

endmodule

// File: tb/tb_multi_rport_axi_memory.sv
// Directed bench for multi_rport_axi_memory: bulk load, lane reads, FIXED burst,
// per-lane backpressure, write-enable gating and reset mid-burst.
module tb_multi_rport_axi_memory;

  localparam int unsigned NS = 32;

  logic                     ACLK = 1'b0;
  logic                     ARESETn, W_EN, R_EN;
  logic                     AWVALID, AWREADY, AWBURST;
  logic [9:0]               AWADDR;
  logic [7:0]               AWLEN;
  logic                     WVALID, WREADY, WLAST;
  logic [31:0]              WDATA;
  logic                     BVALID, BREADY;
  logic [1:0]               BRESP;
  logic                     ARVALID, ARREADY;
  logic [4:0]               ARADDR;
  logic [0:NS-1]            RVALID, RREADY;
  logic [0:NS-1][31:0]      RDATA;
  logic [0:NS-1][1:0]       RRESP;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] wdat [0:255];

  multi_rport_axi_memory dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .W_EN(W_EN), .R_EN(R_EN),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWBURST(AWBURST), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge ACLK);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_burst(input logic [9:0] a, input logic incr, input int len,
                             output int beats, output int bcnt, output logic [1:0] resp);
    int t;
    AWVALID = 1'b1; AWADDR = a; AWBURST = incr; AWLEN = 8'(len);
    t = 0;
    while (!AWREADY && t < 20) begin tick(); t++; end
    chk("aw_accept", 64'(AWREADY), 64'd1);
    tick();
    AWVALID = 1'b0;
    beats = 0;
    for (int i = 0; i <= len; i++) begin
      WVALID = 1'b1; WDATA = wdat[i]; WLAST = (i == len);
      t = 0;
      while (!WREADY && t < 20) begin tick(); t++; end
      if (WREADY) beats++;
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    bcnt = 0; resp = 2'b11; BREADY = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (BVALID) begin bcnt++; resp = BRESP; end
      tick();
    end
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] k);
    int t;
    ARVALID = 1'b1; ARADDR = k;
    t = 0;
    while (!ARREADY && t < 20) begin tick(); t++; end
    chk("ar_accept", 64'(ARREADY), 64'd1);
    tick();
    ARVALID = 1'b0;
  endtask

  initial begin
    int beats, bcnt;
    logic [1:0] resp;
    logic [0:NS-1] exp_v;
    int ks [3] = '{0, 5, 31};

    ARESETn = 1'b1; W_EN = 1'b1; R_EN = 1'b1;
    AWVALID = 1'b0; AWADDR = '0; AWBURST = 1'b0; AWLEN = '0;
    WVALID = 1'b0; WDATA = '0; WLAST = 1'b0; BREADY = 1'b0;
    ARVALID = 1'b0; ARADDR = '0; RREADY = '1;
    tick(); tick();

    // Reset state
    chk("rst_awready", 64'(AWREADY), 64'd0);
    chk("rst_arready", 64'(ARREADY), 64'd0);
    chk("rst_bvalid", 64'(BVALID), 64'd0);
    chk("rst_rvalid", 64'(RVALID), 64'd0);
    ARESETn = 1'b0;
    tick();
    chk("idle_awready", 64'(AWREADY), 64'd1);
    chk("idle_arready", 64'(ARREADY), 64'd1);

    // Load pattern: word a holds a+1
    for (int s = 0; s < 32; s++) begin
      for (int i = 0; i < 32; i++) wdat[i] = 32'(32 * s + i + 1);
      write_burst(10'(32 * s), 1'b1, 31, beats, bcnt, resp);
      chk("load_beats", 64'(beats), 64'd32);
      chk("load_bcnt", 64'(bcnt), 64'd1);
      chk("load_bresp", 64'(resp), 64'd0);
    end

    // Parallel reads across all lanes
    for (int j = 0; j < 3; j++) begin
      do_read(5'(ks[j]));
      chk("rd_rvalid", 64'(RVALID), 64'hFFFF_FFFF);
      for (int i = 0; i < 32; i++) begin
        chk("rd_rdata", 64'(RDATA[i]), 64'(32 * i + ks[j] + 1));
        chk("rd_rresp", 64'(RRESP[i]), 64'd0);
      end
      tick();
      chk("rd_drained", 64'(RVALID), 64'd0);
      chk("rd_arready", 64'(ARREADY), 64'd1);
    end

    // FIXED burst at 37: last beat wins, neighbours untouched
    wdat[0] = 32'hAAAA_0001; wdat[1] = 32'hBBBB_0002;
    wdat[2] = 32'hCCCC_0003; wdat[3] = 32'hDDDD_0004;
    write_burst(10'd37, 1'b0, 3, beats, bcnt, resp);
    chk("fix_beats", 64'(beats), 64'd4);
    chk("fix_bcnt", 64'(bcnt), 64'd1);
    chk("fix_bresp", 64'(resp), 64'd0);
    do_read(5'd5);
    chk("fix_word37", 64'(RDATA[1]), 64'hDDDD_0004);
    chk("fix_lane0", 64'(RDATA[0]), 64'd6);
    tick();
    for (int k = 6; k <= 8; k++) begin
      do_read(5'(k));
      chk("fix_neighbour", 64'(RDATA[1]), 64'(32 + k + 1));
      tick();
    end

    // Lane 3 backpressure
    RREADY = '1; RREADY[3] = 1'b0;
    do_read(5'd2);
    chk("bp_rvalid_all", 64'(RVALID), 64'hFFFF_FFFF);
    tick();
    exp_v = '0; exp_v[3] = 1'b1;
    chk("bp_rvalid_lane3", 64'(RVALID), 64'(exp_v));
    chk("bp_rdata3", 64'(RDATA[3]), 64'd99);
    chk("bp_arready", 64'(ARREADY), 64'd0);
    tick();
    chk("bp_hold", 64'(RVALID), 64'(exp_v));
    RREADY[3] = 1'b1;
    tick();
    chk("bp_release", 64'(RVALID), 64'd0);
    chk("bp_arready_back", 64'(ARREADY), 64'd1);

    // W_EN low blocks the address handshake
    W_EN = 1'b0; AWVALID = 1'b1; AWADDR = 10'd0; AWBURST = 1'b1; AWLEN = 8'd0;
    WVALID = 1'b1; WDATA = 32'hBAD0_BAD0; WLAST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("wen_awready", 64'(AWREADY), 64'd0);
      chk("wen_wready", 64'(WREADY), 64'd0);
    end
    AWVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
    tick();
    W_EN = 1'b1;
    do_read(5'd0);
    chk("wen_mem0", 64'(RDATA[0]), 64'd1);
    tick();

    // Reset mid-burst: no response, memory cleared
    AWVALID = 1'b1; AWADDR = 10'd64; AWBURST = 1'b1; AWLEN = 8'd7;
    tick();
    AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      WVALID = 1'b1; WDATA = 32'hDEAD_0000 + 32'(i);
      tick();
    end
    WVALID = 1'b0;
    ARESETn = 1'b1;
    tick();
    chk("mrst_bvalid", 64'(BVALID), 64'd0);
    chk("mrst_awready", 64'(AWREADY), 64'd0);
    chk("mrst_wready", 64'(WREADY), 64'd0);
    ARESETn = 1'b0;
    tick();
    chk("mrst_awready_back", 64'(AWREADY), 64'd1);
    chk("mrst_wready_idle", 64'(WREADY), 64'd0);
    BREADY = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk("mrst_no_b", 64'(BVALID), 64'd0);
      tick();
    end
    BREADY = 1'b0;
    do_read(5'd0);
    chk("mrst_cleared0", 64'(RDATA[0]), 64'd0);
    chk("mrst_cleared2", 64'(RDATA[2]), 64'd0);
    chk("mrst_cleared31", 64'(RDATA[31]), 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
